// File: rtl/axi_burst_split.sv
// Splits multi-beat AXI4 bursts into single-beat downstream transactions.
// Latency: 3 cycles per read beat, 2 cycles per write beat with a zero-wait slave.
// Backpressure: at most one downstream beat outstanding per path; R and B are held until accepted.
module axi_burst_split #(
    parameter int TAGW = 4
) (
    input  logic            aclk,
    input  logic            rst_l,
    input  logic            s_arvalid,
    output logic            s_arready,
    input  logic [31:0]     s_araddr,
    input  logic [TAGW-1:0] s_arid,
    input  logic [7:0]      s_arlen,
    input  logic [1:0]      s_arburst,
    input  logic [2:0]      s_arsize,
    output logic            s_rvalid,
    input  logic            s_rready,
    output logic [63:0]     s_rdata,
    output logic [1:0]      s_rresp,
    output logic [TAGW-1:0] s_rid,
    output logic            s_rlast,
    input  logic            s_awvalid,
    output logic            s_awready,
    input  logic [31:0]     s_awaddr,
    input  logic [TAGW-1:0] s_awid,
    input  logic [7:0]      s_awlen,
    input  logic [1:0]      s_awburst,
    input  logic [2:0]      s_awsize,
    input  logic            s_wvalid,
    output logic            s_wready,
    input  logic [63:0]     s_wdata,
    input  logic [7:0]      s_wstrb,
    output logic            s_bvalid,
    input  logic            s_bready,
    output logic [1:0]      s_bresp,
    output logic [TAGW-1:0] s_bid,
    output logic            m_arvalid,
    input  logic            m_arready,
    output logic [31:0]     m_araddr,
    output logic [TAGW-1:0] m_arid,
    output logic [7:0]      m_arlen,
    output logic [1:0]      m_arburst,
    output logic [2:0]      m_arsize,
    input  logic            m_rvalid,
    output logic            m_rready,
    input  logic [63:0]     m_rdata,
    input  logic [1:0]      m_rresp,
    input  logic [TAGW-1:0] m_rid,
    input  logic            m_rlast,
    output logic            m_awvalid,
    input  logic            m_awready,
    output logic [31:0]     m_awaddr,
    output logic [TAGW-1:0] m_awid,
    output logic [7:0]      m_awlen,
    output logic [1:0]      m_awburst,
    output logic [2:0]      m_awsize,
    output logic            m_wvalid,
    input  logic            m_wready,
    output logic [63:0]     m_wdata,
    output logic [7:0]      m_wstrb,
    output logic            m_wlast,
    input  logic            m_bvalid,
    output logic            m_bready,
    input  logic [1:0]      m_bresp,
    input  logic [TAGW-1:0] m_bid
);
    typedef enum logic [1:0] {R_IDLE, R_ADDR, R_WAIT, R_OUT} rd_state_t;
    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP, W_B} wr_state_t;

    rd_state_t       r_state;
    wr_state_t       w_state;
    logic [31:0]     r_addr, w_addr;
    logic [TAGW-1:0] r_id, w_id;
    logic [7:0]      r_len, w_len, rcnt, wcnt;
    logic [1:0]      r_burst, w_burst, w_acc;
    logic [2:0]      r_size, w_size;
    logic            w_beat;
    logic            unused_ok;

    // Next beat address; sizes above 8 bytes are clamped to the 64-bit bus width.
    function automatic logic [31:0] step_addr(input logic [31:0] addr, input logic [7:0] len,
                                              input logic [1:0] burst, input logic [2:0] size);
        logic [31:0] bytes;
        logic [31:0] mask;
        bytes = 32'd1 << ((size > 3'd3) ? 3'd3 : size);
        mask  = ({24'd0, len} + 32'd1) * bytes - 32'd1;
        case (burst)
            2'b00:   step_addr = addr;
            2'b10:   step_addr = (addr & ~mask) | ((addr + bytes) & mask);
            default: step_addr = addr + bytes;
        endcase
    endfunction

    // Downstream ids, last flags and the R/B ids are not needed: one beat is ever in flight.
    assign unused_ok = ^{m_rid, m_rlast, m_bid};

    assign m_araddr  = r_addr;
    assign m_arid    = r_id;
    assign m_arlen   = 8'd0;
    assign m_arburst = 2'b01;
    assign m_arsize  = r_size;
    assign s_rid     = r_id;

    assign m_awaddr  = w_addr;
    assign m_awid    = w_id;
    assign m_awlen   = 8'd0;
    assign m_awburst = 2'b01;
    assign m_awsize  = w_size;
    assign m_wlast   = 1'b1;
    assign s_bresp   = w_acc;
    assign s_bid     = w_id;

    // AW and W of a beat travel together and are only released while a beat is due.
    assign w_beat    = (w_state == W_DATA);
    assign m_awvalid = w_beat & s_wvalid;
    assign m_wvalid  = w_beat & s_wvalid;
    assign s_wready  = w_beat & m_awready & m_wready;
    assign m_wdata   = w_beat ? s_wdata : 64'd0;
    assign m_wstrb   = w_beat ? s_wstrb : 8'd0;

    // Read path: issue one single-beat AR, wait for its data, present it upstream, repeat.
    always_ff @(posedge aclk or negedge rst_l) begin
        if (!rst_l) begin
            r_state   <= R_IDLE;
            s_arready <= 1'b1;
            m_arvalid <= 1'b0;
            m_rready  <= 1'b0;
            s_rvalid  <= 1'b0;
            s_rlast   <= 1'b0;
            s_rdata   <= 64'd0;
            s_rresp   <= 2'b00;
            r_addr    <= 32'd0;
            r_id      <= '0;
            r_len     <= 8'd0;
            r_burst   <= 2'b00;
            r_size    <= 3'd0;
            rcnt      <= 8'd0;
        end else begin
            case (r_state)
                R_IDLE: if (s_arvalid) begin
                    r_addr    <= s_araddr;
                    r_id      <= s_arid;
                    r_len     <= s_arlen;
                    r_burst   <= s_arburst;
                    r_size    <= s_arsize;
                    rcnt      <= 8'd0;
                    s_arready <= 1'b0;
                    m_arvalid <= 1'b1;
                    r_state   <= R_ADDR;
                end
                R_ADDR: if (m_arready) begin
                    m_arvalid <= 1'b0;
                    m_rready  <= 1'b1;
                    r_state   <= R_WAIT;
                end
                R_WAIT: if (m_rvalid) begin
                    m_rready <= 1'b0;
                    s_rdata  <= m_rdata;
                    s_rresp  <= m_rresp;
                    s_rlast  <= (rcnt == r_len);
                    s_rvalid <= 1'b1;
                    r_state  <= R_OUT;
                end
                R_OUT: if (s_rready) begin
                    s_rvalid <= 1'b0;
                    s_rlast  <= 1'b0;
                    if (s_rlast) begin
                        s_arready <= 1'b1;
                        r_state   <= R_IDLE;
                    end else begin
                        rcnt      <= rcnt + 8'd1;
                        r_addr    <= step_addr(r_addr, r_len, r_burst, r_size);
                        m_arvalid <= 1'b1;
                        r_state   <= R_ADDR;
                    end
                end
                default: r_state <= R_IDLE;
            endcase
        end
    end

    // Write path: forward one beat, collect its B, keep the worst response for the burst.
    always_ff @(posedge aclk or negedge rst_l) begin
        if (!rst_l) begin
            w_state   <= W_IDLE;
            s_awready <= 1'b1;
            m_bready  <= 1'b0;
            s_bvalid  <= 1'b0;
            w_addr    <= 32'd0;
            w_id      <= '0;
            w_len     <= 8'd0;
            w_burst   <= 2'b00;
            w_size    <= 3'd0;
            wcnt      <= 8'd0;
            w_acc     <= 2'b00;
        end else begin
            case (w_state)
                W_IDLE: if (s_awvalid) begin
                    w_addr    <= s_awaddr;
                    w_id      <= s_awid;
                    w_len     <= s_awlen;
                    w_burst   <= s_awburst;
                    w_size    <= s_awsize;
                    wcnt      <= 8'd0;
                    w_acc     <= 2'b00;
                    s_awready <= 1'b0;
                    w_state   <= W_DATA;
                end
                W_DATA: if (s_wvalid && m_awready && m_wready) begin
                    m_bready <= 1'b1;
                    w_state  <= W_RESP;
                end
                W_RESP: if (m_bvalid) begin
                    m_bready <= 1'b0;
                    if (m_bresp > w_acc) w_acc <= m_bresp;
                    if (wcnt == w_len) begin
                        s_bvalid <= 1'b1;
                        w_state  <= W_B;
                    end else begin
                        wcnt    <= wcnt + 8'd1;
                        w_addr  <= step_addr(w_addr, w_len, w_burst, w_size);
                        w_state <= W_DATA;
                    end
                end
                W_B: if (s_bready) begin
                    s_bvalid  <= 1'b0;
                    s_awready <= 1'b1;
                    w_state   <= W_IDLE;
                end
                default: w_state <= W_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_axi_burst_split.sv
// Bench for axi_burst_split: single-beat memory slave, table vectors and randomized bursts.
// Expected addresses come from closed-form beat arithmetic; data from a reference memory.
// Driving happens 1 time unit after the rising edge, sampling on the falling edge.
module tb_axi_burst_split;
    logic aclk, rst_l;
    logic s_arvalid, s_arready; logic [31:0] s_araddr; logic [3:0] s_arid; logic [7:0] s_arlen;
    logic [1:0] s_arburst; logic [2:0] s_arsize;
    logic s_rvalid, s_rready; logic [63:0] s_rdata; logic [1:0] s_rresp; logic [3:0] s_rid; logic s_rlast;
    logic s_awvalid, s_awready; logic [31:0] s_awaddr; logic [3:0] s_awid; logic [7:0] s_awlen;
    logic [1:0] s_awburst; logic [2:0] s_awsize;
    logic s_wvalid, s_wready; logic [63:0] s_wdata; logic [7:0] s_wstrb;
    logic s_bvalid, s_bready; logic [1:0] s_bresp; logic [3:0] s_bid;
    logic m_arvalid, m_arready; logic [31:0] m_araddr; logic [3:0] m_arid; logic [7:0] m_arlen;
    logic [1:0] m_arburst; logic [2:0] m_arsize;
    logic m_rvalid, m_rready; logic [63:0] m_rdata; logic [1:0] m_rresp; logic [3:0] m_rid; logic m_rlast;
    logic m_awvalid, m_awready; logic [31:0] m_awaddr; logic [3:0] m_awid; logic [7:0] m_awlen;
    logic [1:0] m_awburst; logic [2:0] m_awsize;
    logic m_wvalid, m_wready; logic [63:0] m_wdata; logic [7:0] m_wstrb; logic m_wlast;
    logic m_bvalid, m_bready; logic [1:0] m_bresp; logic [3:0] m_bid;

    axi_burst_split #(.TAGW(4)) dut (
        .aclk(aclk), .rst_l(rst_l),
        .s_arvalid(s_arvalid), .s_arready(s_arready), .s_araddr(s_araddr), .s_arid(s_arid),
        .s_arlen(s_arlen), .s_arburst(s_arburst), .s_arsize(s_arsize),
        .s_rvalid(s_rvalid), .s_rready(s_rready), .s_rdata(s_rdata), .s_rresp(s_rresp),
        .s_rid(s_rid), .s_rlast(s_rlast),
        .s_awvalid(s_awvalid), .s_awready(s_awready), .s_awaddr(s_awaddr), .s_awid(s_awid),
        .s_awlen(s_awlen), .s_awburst(s_awburst), .s_awsize(s_awsize),
        .s_wvalid(s_wvalid), .s_wready(s_wready), .s_wdata(s_wdata), .s_wstrb(s_wstrb),
        .s_bvalid(s_bvalid), .s_bready(s_bready), .s_bresp(s_bresp), .s_bid(s_bid),
        .m_arvalid(m_arvalid), .m_arready(m_arready), .m_araddr(m_araddr), .m_arid(m_arid),
        .m_arlen(m_arlen), .m_arburst(m_arburst), .m_arsize(m_arsize),
        .m_rvalid(m_rvalid), .m_rready(m_rready), .m_rdata(m_rdata), .m_rresp(m_rresp),
        .m_rid(m_rid), .m_rlast(m_rlast),
        .m_awvalid(m_awvalid), .m_awready(m_awready), .m_awaddr(m_awaddr), .m_awid(m_awid),
        .m_awlen(m_awlen), .m_awburst(m_awburst), .m_awsize(m_awsize),
        .m_wvalid(m_wvalid), .m_wready(m_wready), .m_wdata(m_wdata), .m_wstrb(m_wstrb),
        .m_wlast(m_wlast),
        .m_bvalid(m_bvalid), .m_bready(m_bready), .m_bresp(m_bresp), .m_bid(m_bid)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    int cyc = 0;
    always @(posedge aclk) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;
    bit slv_rand = 1'b0;
    logic [31:0] ar_log[$];
    logic [31:0] aw_log[$];
    logic [1:0]  bresp_q[$];
    logic [63:0] smem [logic [31:0]];
    logic [63:0] rmem [logic [31:0]];

    typedef struct {
        bit          wr;
        logic [31:0] addr;
        logic [7:0]  len;
        logic [1:0]  burst;
        logic [2:0]  size;
        logic [3:0]  id;
        logic [1:0]  resp0;
        logic [3:0][31:0] exp;
    } vec_t;
    vec_t vt[9];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    function automatic logic [63:0] init_val(input logic [31:0] k);
        return {k ^ 32'hA5A5_0000, ~k};
    endfunction

    function automatic logic [63:0] slv_rd(input logic [31:0] a);
        logic [31:0] k;
        k = a & ~32'h7;
        return smem.exists(k) ? smem[k] : init_val(k);
    endfunction

    function automatic logic [63:0] ref_rd(input logic [31:0] a);
        logic [31:0] k;
        k = a & ~32'h7;
        return rmem.exists(k) ? rmem[k] : init_val(k);
    endfunction

    // Address of beat i computed directly from the burst rules.
    function automatic logic [31:0] beat_addr(input logic [31:0] a, input logic [7:0] len,
                                              input logic [1:0] burst, input logic [2:0] size, input int i);
        logic [31:0] bytes, tot, base;
        bytes = 32'd1 << ((size > 3'd3) ? 3'd3 : size);
        case (burst)
            2'b00: return a;
            2'b10: begin
                tot  = (32'(len) + 32'd1) * bytes;
                base = a - (a % tot);
                return base + ((a - base + 32'(i) * bytes) % tot);
            end
            default: return a + 32'(i) * bytes;
        endcase
    endfunction

    // Downstream single-beat memory slave with optional random wait states.
    initial begin : slave
        bit ar_hs, r_hs, w_hs, b_hs, rd_pend, wr_pend, rdy;
        logic [31:0] ar_a, w_a, rd_a, k;
        logic [63:0] w_d, old;
        logic [7:0]  w_s;
        int rd_wait, wr_wait;
        m_arready = 0; m_rvalid = 0; m_rdata = 0; m_rresp = 0; m_rid = 0; m_rlast = 0;
        m_awready = 0; m_wready = 0; m_bvalid = 0; m_bresp = 0; m_bid = 0;
        rd_pend = 0; wr_pend = 0; rd_wait = 0; wr_wait = 0; rd_a = 0;
        forever begin
            @(negedge aclk);
            ar_hs = m_arvalid && m_arready; ar_a = m_araddr;
            r_hs  = m_rvalid && m_rready;
            w_hs  = m_awvalid && m_awready && m_wvalid && m_wready;
            w_a = m_awaddr; w_d = m_wdata; w_s = m_wstrb;
            b_hs  = m_bvalid && m_bready;
            @(posedge aclk); #1;
            if (!rst_l) begin
                m_rvalid = 0; m_bvalid = 0; rd_pend = 0; wr_pend = 0;
                m_arready = 0; m_awready = 0; m_wready = 0;
            end else begin
                if (ar_hs) begin
                    ar_log.push_back(ar_a); rd_pend = 1; rd_a = ar_a;
                    rd_wait = slv_rand ? $urandom_range(0, 3) : 0;
                end
                if (r_hs) m_rvalid = 0;
                if (rd_pend) begin
                    if (rd_wait == 0) begin
                        m_rvalid = 1; m_rdata = slv_rd(rd_a); m_rresp = 2'b00; rd_pend = 0;
                    end else rd_wait--;
                end
                if (w_hs) begin
                    aw_log.push_back(w_a);
                    k = w_a & ~32'h7; old = slv_rd(k);
                    for (int b = 0; b < 8; b++) if (w_s[b]) old[8*b +: 8] = w_d[8*b +: 8];
                    smem[k] = old;
                    wr_pend = 1; wr_wait = slv_rand ? $urandom_range(0, 3) : 0;
                end
                if (b_hs) m_bvalid = 0;
                if (wr_pend) begin
                    if (wr_wait == 0) begin
                        m_bvalid = 1; m_bresp = (bresp_q.size() > 0) ? bresp_q.pop_front() : 2'b00;
                        wr_pend = 0;
                    end else wr_wait--;
                end
                rdy = slv_rand ? (($urandom % 2) != 0) : 1'b1;
                m_arready = slv_rand ? (($urandom % 2) != 0) : 1'b1;
                m_awready = rdy; m_wready = rdy;
            end
        end
    end

    // rmode: 0 = always ready, 1 = toggle with cycle, 2 = random.
    task automatic do_read(input logic [31:0] a, input logic [7:0] len, input logic [1:0] burst,
                           input logic [2:0] size, input logic [3:0] id, input int rmode, input bit tchk);
        int base, got, t0, t1;
        bit held_v;
        logic [63:0] held_d;
        base = ar_log.size(); got = 0; held_v = 0; held_d = 0; t0 = 0; t1 = 0;
        @(posedge aclk); #1;
        s_arvalid = 1; s_araddr = a; s_arid = id; s_arlen = len; s_arburst = burst; s_arsize = size;
        for (int n = 0; n < 200; n++) begin
            @(negedge aclk);
            if (s_arready) break;
        end
        chk("ar_accept", s_arready, 1);
        t0 = cyc;
        @(posedge aclk); #1;
        s_arvalid = 0;
        for (int c = 0; c < 3000 && got <= int'(len); c++) begin
            s_rready = (rmode == 0) ? 1'b1 : (rmode == 1) ? cyc[0] : (($urandom % 2) != 0);
            @(negedge aclk);
            if (c == 0 && tchk) chk("ar_vld_next_cycle", m_arvalid, 1);
            if (held_v) begin
                chk("r_hold_vld", s_rvalid, 1);
                chk("r_hold_dat", s_rdata, held_d);
            end
            held_v = 0;
            if (s_rvalid) begin
                if (s_rready) begin
                    chk("r_data", s_rdata, ref_rd(beat_addr(a, len, burst, size, got)));
                    chk("r_id", s_rid, id);
                    chk("r_last", s_rlast, got == int'(len));
                    chk("r_resp", s_rresp, 0);
                    got++;
                    t1 = cyc;
                end else begin
                    held_v = 1; held_d = s_rdata;
                end
            end
            @(posedge aclk); #1;
        end
        s_rready = 0;
        chk("r_beats", got, int'(len) + 1);
        chk("ar_count", ar_log.size() - base, int'(len) + 1);
        for (int i = 0; i <= int'(len) && base + i < ar_log.size(); i++)
            chk("m_araddr", ar_log[base + i], beat_addr(a, len, burst, size, i));
        if (tchk) chk("r_latency", t1 - t0, 3 * (int'(len) + 1));
    endtask

    // wmode: 0 = wvalid held, 1 = random gaps. Caller fills bresp_q for downstream responses.
    task automatic do_write(input logic [31:0] a, input logic [7:0] len, input logic [1:0] burst,
                            input logic [2:0] size, input logic [3:0] id, input int wmode,
                            input logic [1:0] exp_resp, input bit tchk);
        int base, sent, t0, t1;
        bit done;
        logic [63:0] cur_d, old;
        logic [7:0]  cur_s;
        logic [31:0] k;
        base = aw_log.size(); sent = 0; done = 0; t0 = 0; t1 = 0;
        cur_d = {$urandom, $urandom}; cur_s = 8'($urandom);
        @(posedge aclk); #1;
        s_awvalid = 1; s_awaddr = a; s_awid = id; s_awlen = len; s_awburst = burst; s_awsize = size;
        for (int n = 0; n < 200; n++) begin
            @(negedge aclk);
            if (s_awready) break;
        end
        chk("aw_accept", s_awready, 1);
        t0 = cyc;
        @(posedge aclk); #1;
        s_awvalid = 0; s_bready = 1;
        for (int c = 0; c < 3000 && !done; c++) begin
            s_wvalid = (sent <= int'(len)) && (wmode == 0 || ($urandom % 2) != 0);
            s_wdata = cur_d; s_wstrb = cur_s;
            @(negedge aclk);
            if (s_wvalid && s_wready) begin
                k = beat_addr(a, len, burst, size, sent) & ~32'h7;
                old = ref_rd(k);
                for (int b = 0; b < 8; b++) if (cur_s[b]) old[8*b +: 8] = cur_d[8*b +: 8];
                rmem[k] = old;
                sent++;
                cur_d = {$urandom, $urandom}; cur_s = 8'($urandom);
            end
            if (s_bvalid) begin
                chk("b_resp", s_bresp, exp_resp);
                chk("b_id", s_bid, id);
                chk("w_beats_before_b", sent, int'(len) + 1);
                t1 = cyc; done = 1;
            end
            @(posedge aclk); #1;
        end
        s_wvalid = 0;
        chk("b_seen", done, 1);
        @(negedge aclk);
        chk("b_once", s_bvalid, 0);
        chk("aw_count", aw_log.size() - base, int'(len) + 1);
        for (int i = 0; i <= int'(len) && base + i < aw_log.size(); i++)
            chk("m_awaddr", aw_log[base + i], beat_addr(a, len, burst, size, i));
        if (tchk) chk("w_latency", t1 - t0, 2 * int'(len) + 3);
    endtask

    task automatic set_vec(input int i, input bit wr, input logic [31:0] addr, input logic [7:0] len,
                           input logic [1:0] burst, input logic [2:0] size, input logic [3:0] id,
                           input logic [1:0] resp0, input logic [31:0] e0, input logic [31:0] e1,
                           input logic [31:0] e2, input logic [31:0] e3);
        vt[i].wr = wr; vt[i].addr = addr; vt[i].len = len; vt[i].burst = burst;
        vt[i].size = size; vt[i].id = id; vt[i].resp0 = resp0;
        vt[i].exp[0] = e0; vt[i].exp[1] = e1; vt[i].exp[2] = e2; vt[i].exp[3] = e3;
    endtask

    initial begin
        logic [31:0] a, bytes;
        logic [7:0]  len;
        logic [1:0]  burst, er, rr;
        logic [2:0]  size;
        int base, n;
        rst_l = 0;
        s_arvalid = 0; s_araddr = 0; s_arid = 0; s_arlen = 0; s_arburst = 0; s_arsize = 0; s_rready = 0;
        s_awvalid = 0; s_awaddr = 0; s_awid = 0; s_awlen = 0; s_awburst = 0; s_awsize = 0;
        s_wvalid = 0; s_wdata = 0; s_wstrb = 0; s_bready = 0;

        set_vec(0, 0, 32'h1000, 3, 2'b01, 3, 5, 0, 32'h1000, 32'h1008, 32'h1010, 32'h1018);
        set_vec(1, 1, 32'h2018, 3, 2'b10, 3, 6, 0, 32'h2018, 32'h2000, 32'h2008, 32'h2010);
        set_vec(2, 0, 32'h0040, 2, 2'b00, 3, 1, 0, 32'h0040, 32'h0040, 32'h0040, 0);
        set_vec(3, 1, 32'h3000, 1, 2'b01, 3, 2, 2'b10, 32'h3000, 32'h3008, 0, 0);
        set_vec(4, 0, 32'h0104, 3, 2'b01, 2, 7, 0, 32'h0104, 32'h0108, 32'h010C, 32'h0110);
        set_vec(5, 0, 32'h003C, 3, 2'b10, 2, 8, 0, 32'h003C, 32'h0030, 32'h0034, 32'h0038);
        set_vec(6, 0, 32'hFFFF_FFF8, 1, 2'b01, 3, 4, 0, 32'hFFFF_FFF8, 32'h0000_0000, 0, 0);
        set_vec(7, 1, 32'h0200, 1, 2'b11, 0, 3, 0, 32'h0200, 32'h0201, 0, 0);
        set_vec(8, 0, 32'h0300, 1, 2'b01, 7, 15, 0, 32'h0300, 32'h0308, 0, 0);

        repeat (3) @(posedge aclk);
        @(negedge aclk);
        chk("rst_readies", {s_arready, s_awready}, 2'b11);
        chk("rst_valids", {s_rvalid, s_bvalid, m_arvalid, m_awvalid, m_wvalid, m_rready, m_bready, s_rlast}, 0);
        chk("rst_bresp", s_bresp, 0);
        #2 rst_l = 1;

        // Directed vectors with a zero-wait slave, including latency checks.
        for (int v = 0; v < 9; v++) begin
            if (vt[v].wr) begin
                base = aw_log.size();
                bresp_q.push_back(vt[v].resp0);
                for (int i = 0; i < int'(vt[v].len); i++) bresp_q.push_back(2'b00);
                do_write(vt[v].addr, vt[v].len, vt[v].burst, vt[v].size, vt[v].id, 0, vt[v].resp0, 1);
                for (int i = 0; i <= int'(vt[v].len) && base + i < aw_log.size(); i++)
                    chk("vec_awaddr", aw_log[base + i], vt[v].exp[i]);
            end else begin
                base = ar_log.size();
                do_read(vt[v].addr, vt[v].len, vt[v].burst, vt[v].size, vt[v].id, 0, 1);
                for (int i = 0; i <= int'(vt[v].len) && base + i < ar_log.size(); i++)
                    chk("vec_araddr", ar_log[base + i], vt[v].exp[i]);
            end
        end

        // Concurrent read and write with toggling s_rready, then read back what was written.
        for (int i = 0; i < 4; i++) bresp_q.push_back(2'b00);
        fork
            do_read(32'h5000, 3, 2'b01, 3, 10, 1, 0);
            do_write(32'h9000, 3, 2'b01, 3, 11, 0, 2'b00, 0);
        join
        do_read(32'h9000, 3, 2'b01, 3, 12, 1, 0);

        // Randomized bursts with wait states: write a region, then read it back.
        slv_rand = 1;
        for (int it = 0; it < 20; it++) begin
            burst = 2'($urandom);
            size  = 3'($urandom_range(0, 3));
            len   = (burst == 2'b10) ? 8'((1 << $urandom_range(1, 4)) - 1) : 8'($urandom_range(0, 7));
            bytes = 32'd1 << size;
            a     = ($urandom & 32'h0000_FFF8) & ~(bytes - 1);
            er    = 2'b00;
            for (int i = 0; i <= int'(len); i++) begin
                rr = 2'($urandom);
                bresp_q.push_back(rr);
                if (rr > er) er = rr;
            end
            do_write(a, len, burst, size, 4'($urandom), int'($urandom % 2), er, 0);
            do_read(a, len, burst, size, 4'($urandom), 2, 0);
        end
        slv_rand = 0;
        bresp_q.delete();

        // Reset during the second beat of a len-7 read.
        @(posedge aclk); #1;
        s_arvalid = 1; s_araddr = 32'h6000; s_arid = 9; s_arlen = 7; s_arburst = 2'b01; s_arsize = 3;
        s_rready = 1;
        for (int k = 0; k < 100; k++) begin
            @(negedge aclk);
            if (s_arready) break;
        end
        chk("rst_ar_accept", s_arready, 1);
        base = ar_log.size();
        @(posedge aclk); #1;
        s_arvalid = 0;
        for (int k = 0; k < 100; k++) begin
            @(negedge aclk);
            if (ar_log.size() - base >= 2) break;
        end
        chk("rst_second_beat", ar_log.size() - base, 2);
        #2 rst_l = 0;
        #1;
        chk("midrst_valids", {s_rvalid, s_bvalid, m_arvalid, m_awvalid, m_wvalid, m_rready, m_bready, s_rlast}, 0);
        chk("midrst_readies", {s_arready, s_awready}, 2'b11);
        n = ar_log.size();
        repeat (3) @(posedge aclk);
        @(negedge aclk);
        #2 rst_l = 1;
        s_rready = 0;
        repeat (4) @(negedge aclk);
        chk("no_req_after_rst", ar_log.size(), n);
        chk("no_rvalid_after_rst", s_rvalid, 0);
        chk("arready_after_rst", s_arready, 1);
        do_read(32'h7000, 0, 2'b01, 3, 3, 0, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
